// File: rtl/led_shift_ctrl.sv
// Four-LED shift display controller: switch sync/debounce, step tick generation
// and a mode FSM driving an idle, rotating, bouncing or paused one-hot pattern.
module led_shift_ctrl #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [3:0] sw,
  output logic [3:0] led,
  output logic       tick_out,
  output logic [1:0] state_out
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_BOUNCE = 2'd2;
  localparam logic [1:0] ST_PAUSE  = 2'd3;

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TK_W = $clog2(TICK_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);

  logic [3:0]      sync1_reg, sync2_reg;
  logic [3:0]      cand_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic [3:0]      sw_db_reg;
  logic [1:0]      state_reg, state_next;
  logic [TK_W-1:0] tick_cnt_reg, tick_cnt_next;
  logic            tick_reg;
  logic [3:0]      led_reg, led_next;
  logic            bounce_dir_reg, bounce_dir_next;
  logic [3:0]      rot_left, rot_right;
  logic            run_state, step, led_onehot;

  // Two-flop synchronizer on the raw switches.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync1_reg <= 4'b0000;
      sync2_reg <= 4'b0000;
    end else begin
      sync1_reg <= sw;
      sync2_reg <= sync1_reg;
    end
  end

  // One counter debounces the whole vector; any bit change restarts the wait.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cand_reg   <= 4'b0000;
      db_cnt_reg <= '0;
      sw_db_reg  <= 4'b0000;
    end else if (sync2_reg != cand_reg) begin
      cand_reg   <= sync2_reg;
      db_cnt_reg <= '0;
    end else if (db_cnt_reg == DB_LAST) begin
      sw_db_reg  <= cand_reg;
    end else begin
      db_cnt_reg <= db_cnt_reg + DB_W'(1);
    end
  end

  always_comb begin
    state_next = ST_SHIFT;
    if (!sw_db_reg[0]) begin
      state_next = ST_IDLE;
    end else if (sw_db_reg[3]) begin
      state_next = ST_PAUSE;
    end else if (sw_db_reg[2]) begin
      state_next = ST_BOUNCE;
    end
  end

  assign run_state = (state_reg == ST_SHIFT) || (state_reg == ST_BOUNCE);
  assign step      = run_state && (tick_cnt_reg == TK_LAST);

  always_comb begin
    tick_cnt_next = tick_cnt_reg;
    case (state_reg)
      ST_IDLE:   tick_cnt_next = '0;
      ST_SHIFT,
      ST_BOUNCE: tick_cnt_next = step ? '0 : tick_cnt_reg + TK_W'(1);
      default:   tick_cnt_next = tick_cnt_reg;
    endcase
  end

  // Left moves toward led[3], right toward led[0].
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign rot_left[gi]  = led_reg[(gi + 3) % 4];
    assign rot_right[gi] = led_reg[(gi + 1) % 4];
  end

  assign led_onehot = $onehot(led_reg);

  always_comb begin
    led_next        = led_reg;
    bounce_dir_next = bounce_dir_reg;
    if (step) begin
      if (!led_onehot) begin
        led_next = 4'b0001;
      end else if (state_reg == ST_SHIFT) begin
        led_next = sw_db_reg[1] ? rot_right : rot_left;
      end else if (!bounce_dir_reg) begin
        if (led_reg[3]) begin
          led_next        = rot_right;
          bounce_dir_next = 1'b1;
        end else begin
          led_next = rot_left;
        end
      end else begin
        if (led_reg[0]) begin
          led_next        = rot_left;
          bounce_dir_next = 1'b0;
        end else begin
          led_next = rot_right;
        end
      end
    end
    // Entry into bounce takes its starting direction from the direction switch.
    if ((state_next == ST_BOUNCE) && (state_reg != ST_BOUNCE)) begin
      bounce_dir_next = sw_db_reg[1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      tick_cnt_reg   <= '0;
      tick_reg       <= 1'b0;
      led_reg        <= 4'b0001;
      bounce_dir_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tick_cnt_reg   <= tick_cnt_next;
      tick_reg       <= step;
      led_reg        <= led_next;
      bounce_dir_reg <= bounce_dir_next;
    end
  end

  assign led       = led_reg;
  assign tick_out  = tick_reg;
  assign state_out = state_reg;

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Self-checking bench for led_shift_ctrl: vector table, hand-written corner
// sequences and randomized switch activity against a per-cycle reference model.
module tb_led_shift_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int DB_CYCLES = 3;

  logic       clk_in;
  logic       rst_n;
  logic [3:0] sw;
  logic [3:0] led;
  logic       tick_out;
  logic [1:0] state_out;

  int n_vec;
  int n_err;

  led_shift_ctrl #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .sw        (sw),
    .led       (led),
    .tick_out  (tick_out),
    .state_out (state_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reference model: LED as a position index, debounce as a run length of
  // identical synchronized samples, modes from the priority rules.
  logic [3:0] m_s1, m_s2, m_run_val, m_db, m_led;
  logic [1:0] m_mode;
  logic       m_tick;
  int         m_run_len, m_phase, m_pos, m_bdir;

  always @(posedge clk_in) begin : model
    logic [3:0] db_n;
    logic [1:0] mode_n;
    if (!rst_n) begin
      m_s1 = 4'b0000; m_s2 = 4'b0000; m_run_val = 4'b0000; m_run_len = 1;
      m_db = 4'b0000; m_mode = 2'd0; m_phase = 0; m_pos = 0; m_bdir = 0;
      m_tick = 1'b0;
    end else begin
      if (m_s2 == m_run_val) begin
        if (m_run_len < 1000) m_run_len++;
      end else begin
        m_run_val = m_s2;
        m_run_len = 1;
      end
      db_n = (m_run_len >= DB_CYCLES + 1) ? m_run_val : m_db;
      if (!m_db[0])     mode_n = 2'd0;
      else if (m_db[3]) mode_n = 2'd3;
      else if (m_db[2]) mode_n = 2'd2;
      else              mode_n = 2'd1;
      m_tick = 1'b0;
      if (m_mode == 2'd1 || m_mode == 2'd2) begin
        if (m_phase == TICK_DIV - 1) begin
          m_phase = 0;
          m_tick  = 1'b1;
          if (m_mode == 2'd1) begin
            m_pos = m_db[1] ? (m_pos + 3) % 4 : (m_pos + 1) % 4;
          end else if (m_bdir == 0) begin
            if (m_pos == 3) begin m_bdir = 1; m_pos = 2; end
            else m_pos = m_pos + 1;
          end else begin
            if (m_pos == 0) begin m_bdir = 0; m_pos = 1; end
            else m_pos = m_pos - 1;
          end
        end else begin
          m_phase = m_phase + 1;
        end
      end else if (m_mode == 2'd0) begin
        m_phase = 0;
      end
      if (mode_n == 2'd2 && m_mode != 2'd2) m_bdir = int'(m_db[1]);
      m_s2 = m_s1;
      m_s1 = sw;
      m_db = db_n;
      m_mode = mode_n;
    end
    m_led = 4'b0001 << m_pos;
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Advance one cycle and compare the outputs with the model.
  task automatic cycle();
    @(negedge clk_in);
    check("model", {1'b0, led, tick_out, state_out}, {1'b0, m_led, m_tick, m_mode});
  endtask

  task automatic wait_tick(input string name, input int max, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!tick_out && n < max);
    check({name, "_tick_seen"}, {7'b0, tick_out}, 8'h01);
  endtask

  task automatic wait_state(input string name, input logic [1:0] s, input int max);
    int n;
    n = 0;
    while (state_out !== s && n < max) begin
      cycle();
      n++;
    end
    check({name, "_state"}, {6'b0, state_out}, {6'b0, s});
  endtask

  task automatic chk_led(input string name, input logic [3:0] exp);
    check(name, {4'b0, led}, {4'b0, exp});
    $display("%s: led=%b state=%0d tick=%0d", name, led, state_out, tick_out);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       rst_n;
    logic [3:0] sw;
    int         cycles;
    logic [3:0] led;
    logic       tick;
    logic [1:0] state;
  } vec_t;

  vec_t tbl[8];
  logic [3:0] bounce_exp[7];
  int n;
  int hold;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    sw    = 4'b1111;

    tbl[0] = '{1'b0, 4'b1111, 3,  4'b0001, 1'b0, 2'd0};
    tbl[1] = '{1'b1, 4'b0000, 50, 4'b0001, 1'b0, 2'd0};
    tbl[2] = '{1'b1, 4'b0001, 9,  4'b0001, 1'b0, 2'd1};
    tbl[3] = '{1'b1, 4'b0001, 2,  4'b0010, 1'b1, 2'd1};
    tbl[4] = '{1'b1, 4'b0001, 4,  4'b0100, 1'b1, 2'd1};
    tbl[5] = '{1'b1, 4'b0001, 4,  4'b1000, 1'b1, 2'd1};
    tbl[6] = '{1'b1, 4'b0001, 4,  4'b0001, 1'b1, 2'd1};
    tbl[7] = '{1'b1, 4'b0001, 1,  4'b0001, 1'b0, 2'd1};

    for (int i = 0; i < 8; i++) begin
      rst_n = tbl[i].rst_n;
      sw    = tbl[i].sw;
      repeat (tbl[i].cycles) cycle();
      check($sformatf("tbl%0d", i), {1'b0, led, tick_out, state_out},
            {1'b0, tbl[i].led, tbl[i].tick, tbl[i].state});
      $display("tbl%0d: rst_n=%0d sw=%b led=%b tick=%0d state=%0d",
               i, tbl[i].rst_n, tbl[i].sw, led, tick_out, state_out);
    end

    // Right rotate from reset, then a direction glitch, then idle glitch.
    do_reset();
    sw = 4'b0011;
    wait_tick("right1", 20, n);
    check("right1_latency", 8'(n), 8'(7 + TICK_DIV));
    chk_led("right1", 4'b1000);
    wait_tick("right2", 10, n);
    check("right2_period", 8'(n), 8'(TICK_DIV));
    chk_led("right2", 4'b0100);
    sw = 4'b0001;
    cycle();
    cycle();
    sw = 4'b0011;
    wait_tick("glitch1", 10, n);
    chk_led("glitch1", 4'b0010);
    wait_tick("glitch2", 10, n);
    chk_led("glitch2", 4'b0001);
    sw = 4'b0000;
    wait_state("to_idle", 2'd0, 20);
    chk_led("to_idle", 4'b1000);
    sw = 4'b0001;
    cycle();
    cycle();
    sw = 4'b0000;
    repeat (20) cycle();
    check("idle_glitch_state", {6'b0, state_out}, 8'h00);
    chk_led("idle_glitch", 4'b1000);

    // Bounce from 0001 with no wrap at the ends.
    do_reset();
    sw = 4'b0101;
    bounce_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    for (int i = 0; i < 7; i++) begin
      wait_tick($sformatf("bounce%0d", i), 20, n);
      chk_led($sformatf("bounce%0d", i), bounce_exp[i]);
    end

    // Pause mid-run, then resume from the held count.
    do_reset();
    sw = 4'b0001;
    wait_tick("prepause", 20, n);
    chk_led("prepause", 4'b0010);
    cycle();
    cycle();
    sw = 4'b1001;
    wait_state("pause", 2'd3, 20);
    chk_led("pause_entry", 4'b1000);
    for (int i = 0; i < 20; i++) begin
      cycle();
      check($sformatf("pause_hold%0d", i), {1'b0, led, tick_out, state_out},
            {1'b0, 4'b1000, 1'b0, 2'd3});
    end
    sw = 4'b0001;
    wait_state("resume", 2'd1, 20);
    wait_tick("resume", 10, n);
    check("resume_latency", 8'(n), 8'd3);
    chk_led("resume", 4'b0001);

    // Stop, re-run, and reset during a step cycle.
    sw = 4'b0000;
    wait_state("stop", 2'd0, 20);
    repeat (10) cycle();
    check("stop_state", {6'b0, state_out}, 8'h00);
    chk_led("stop_hold", 4'b0010);
    sw = 4'b0001;
    wait_state("rerun", 2'd1, 20);
    wait_tick("rerun", 10, n);
    check("rerun_latency", 8'(n), 8'(TICK_DIV));
    chk_led("rerun", 4'b0100);
    cycle();
    cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    check("rst_step", {1'b0, led, tick_out, state_out}, {1'b0, 4'b0001, 1'b0, 2'd0});
    $display("rst_step: led=%b tick=%0d state=%0d", led, tick_out, state_out);
    rst_n = 1'b1;

    // Randomized switch activity; every cycle is checked against the model.
    for (int b = 0; b < 150; b++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
      end
      sw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) sw[0] = 1'b1;
      hold = $urandom_range(1, 24);
      repeat (hold) cycle();
      $display("burst %0d: sw=%b hold=%0d led=%b state=%0d", b, sw, hold, led, state_out);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
